// File: rtl/modn_timer.sv
// Cascaded mixed-modulus down-counter timer (mm:ss by default) with
// load/clear, start/stop/pause control and a one-cycle completion pulse.
module modn_timer #(
    parameter int                  DIGITS = 4,
    parameter logic [4*DIGITS-1:0] MODS   = {4'd10, 4'd10, 4'd6, 4'd10}
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   input_number,
    input  logic                  loadn,
    input  logic                  clearn,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  tick,
    output logic [4*DIGITS-1:0]   output_number,
    output logic [DIGITS-1:0]     tc,
    output logic                  zero,
    output logic                  running,
    output logic                  done,
    output logic                  finished
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t                state, state_next;
    logic [4*DIGITS-1:0]   count, count_next;
    logic [4*DIGITS-1:0]   loaded, decremented, count_update;
    logic                  borrow;
    logic                  prefix_zero;
    logic                  count_is_one;
    logic                  can_start;
    logic                  done_q, done_next;

    always_comb begin
        loaded      = '0;
        decremented = '0;
        borrow      = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (input_number[4*i +: 4] > MODS[4*i +: 4] - 4'd1)
                loaded[4*i +: 4] = MODS[4*i +: 4] - 4'd1;
            else
                loaded[4*i +: 4] = input_number[4*i +: 4];

            if (!borrow) begin
                decremented[4*i +: 4] = count[4*i +: 4];
            end else if (count[4*i +: 4] == 4'd0) begin
                decremented[4*i +: 4] = MODS[4*i +: 4] - 4'd1;
            end else begin
                decremented[4*i +: 4] = count[4*i +: 4] - 4'd1;
                borrow                = 1'b0;
            end
        end
    end

    always_comb begin
        tc          = '0;
        prefix_zero = (state == RUN);
        for (int i = 0; i < DIGITS; i++) begin
            prefix_zero = prefix_zero && (count[4*i +: 4] == 4'd0);
            tc[i]       = prefix_zero;
        end
    end

    assign count_update = !clearn ? '0 : (!loadn ? loaded : count);
    assign count_is_one = (count == (4*DIGITS)'(1));
    // Start is judged on the pre-update count; the post-update check keeps
    // a same-cycle clear/load-to-zero from ever entering RUN at zero.
    assign can_start    = start && !stop && (count != '0) && (count_update != '0);

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE, PAUSE: begin
                count_next = count_update;
                if (can_start)
                    state_next = RUN;
            end
            RUN: begin
                if (stop) begin
                    state_next = PAUSE;
                end else if (tick) begin
                    count_next = decremented;
                    if (count_is_one)
                        state_next = DONE;
                end
            end
            DONE: begin
                if (!clearn || !loadn) begin
                    state_next = IDLE;
                    count_next = count_update;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    assign done_next = (state_next == DONE) && (state != DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            done_q <= done_next;
        end
    end

    assign output_number = count;
    assign zero          = (count == '0);
    assign running       = (state == RUN);
    assign finished      = (state == DONE);
    assign done          = done_q;

endmodule
